// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: handshake FSM states and
// the saturation limit used by performance counters.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  // All-ones value for a counter of width w (w <= 64).
  function automatic logic [63:0] sat_max(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for performance monitoring; holds at all-ones and
// clears only on reset.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Ready/valid pipeline-stage register with a two-entry skid buffer, explicit
// stall/flush controls and a saturating back-pressure counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int CNT_W         = 16,
  parameter bit ZERO_ON_FLUSH = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  bp_cnt_o
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;
  logic              drain;
  logic              bp_inc;

  // Handshake outputs decode the state register only, so out_ready_i and
  // stall_i never reach in_ready_o combinationally.
  assign in_ready_o  = (state_q != SKID);
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;

  assign accept = in_valid_i & in_ready_o;
  assign drain  = out_valid_o & out_ready_i & ~stall_i;
  assign bp_inc = out_valid_o & ~drain & ~flush_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = FULL;
            main_d  = in_data_i;
          end
        end
        FULL: begin
          if (accept && drain) begin
            main_d = in_data_i;
          end else if (accept) begin
            state_d = SKID;
            skid_d  = in_data_i;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (drain) begin
            state_d = FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Stage boundary: state and payload registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_bp_cnt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .inc_i  (bp_inc),
    .cnt_o  (bp_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (zeroing flush, holding
// flush, 4-bit counter) share one stimulus stream.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic        stall;
  logic        flush;

  logic        a_ir, a_ov, b_ir, b_ov, c_ir, c_ov;
  logic [63:0] a_d, b_d, c_d;
  logic [15:0] a_bp, b_bp;
  logic [3:0]  c_bp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .CNT_W(16), .ZERO_ON_FLUSH(1'b1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(a_ir), .out_valid_o(a_ov), .out_data_o(a_d),
    .out_ready_i(out_ready), .stall_i(stall), .flush_i(flush), .bp_cnt_o(a_bp));

  pipe_stage_reg #(.DATA_W(64), .CNT_W(16), .ZERO_ON_FLUSH(1'b0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(b_ir), .out_valid_o(b_ov), .out_data_o(b_d),
    .out_ready_i(out_ready), .stall_i(stall), .flush_i(flush), .bp_cnt_o(b_bp));

  pipe_stage_reg #(.DATA_W(64), .CNT_W(4), .ZERO_ON_FLUSH(1'b1)) dut_c (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(c_ir), .out_valid_o(c_ov), .out_data_o(c_d),
    .out_ready_i(out_ready), .stall_i(stall), .flush_i(flush), .bp_cnt_o(c_bp));

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [63:0] id;
    logic        ordy;
    logic        stl;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [63:0] e_d;
    logic [63:0] e_db;
    logic [15:0] e_bp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic iv, input logic [63:0] id,
                              input logic ordy, input logic stl, input logic fl,
                              input logic e_ir, input logic e_ov,
                              input logic [63:0] e_d, input logic [63:0] e_db,
                              input logic [15:0] e_bp);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.id = id; v.ordy = ordy; v.stl = stl; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_d = e_d; v.e_db = e_db; v.e_bp = e_bp;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [63:0] id,
                       input logic ordy, input logic stl, input logic fl);
    rst_n = r; in_valid = iv; in_data = id; out_ready = ordy; stall = stl; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    stall = 1'b0; flush = 1'b0;

    //   rst iv  data   ordy stl fl   ir ov  data_a data_b bp
    add(0, 0, 64'h0,  0, 0, 0,   1, 0, 64'h0,  64'h0,  0);  // reset
    add(1, 1, 64'h1,  1, 0, 0,   1, 1, 64'h1,  64'h1,  0);  // streaming
    add(1, 1, 64'h2,  1, 0, 0,   1, 1, 64'h2,  64'h2,  0);
    add(1, 1, 64'h3,  1, 0, 0,   1, 1, 64'h3,  64'h3,  0);
    add(1, 0, 64'h0,  1, 0, 0,   1, 0, 64'h3,  64'h3,  0);
    add(1, 1, 64'hA,  0, 0, 0,   1, 1, 64'hA,  64'hA,  0);  // stall sequence
    add(1, 1, 64'hB,  1, 1, 0,   0, 1, 64'hA,  64'hA,  1);
    add(1, 1, 64'hC,  1, 1, 0,   0, 1, 64'hA,  64'hA,  2);
    add(1, 1, 64'hC,  1, 1, 0,   0, 1, 64'hA,  64'hA,  3);
    add(1, 1, 64'hC,  1, 0, 0,   1, 1, 64'hB,  64'hB,  3);
    add(1, 1, 64'hC,  1, 0, 0,   1, 1, 64'hC,  64'hC,  3);
    add(1, 0, 64'h0,  1, 0, 0,   1, 0, 64'hC,  64'hC,  3);
    add(1, 1, 64'h11, 0, 0, 0,   1, 1, 64'h11, 64'h11, 3);  // fill to SKID
    add(1, 1, 64'h12, 0, 0, 0,   0, 1, 64'h11, 64'h11, 4);
    add(1, 1, 64'hD,  0, 0, 1,   1, 0, 64'h0,  64'h11, 4);  // flush in SKID
    add(1, 0, 64'h0,  1, 0, 0,   1, 0, 64'h0,  64'h11, 4);
    add(1, 1, 64'h21, 1, 0, 0,   1, 1, 64'h21, 64'h21, 4);  // accept right after flush
    add(1, 0, 64'h0,  1, 1, 1,   1, 0, 64'h0,  64'h21, 4);  // flush + stall
    add(1, 1, 64'h31, 0, 0, 0,   1, 1, 64'h31, 64'h31, 4);
    add(1, 1, 64'h32, 0, 0, 0,   0, 1, 64'h31, 64'h31, 5);
    add(0, 1, 64'h33, 0, 0, 0,   1, 0, 64'h0,  64'h0,  0);  // reset in SKID
    add(1, 0, 64'h0,  1, 0, 0,   1, 0, 64'h0,  64'h0,  0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].stl, tbl[i].fl);
      chk("in_ready",  i, {63'd0, a_ir}, {63'd0, tbl[i].e_ir});
      chk("out_valid", i, {63'd0, a_ov}, {63'd0, tbl[i].e_ov});
      chk("out_data",  i, a_d, tbl[i].e_d);
      chk("bp_cnt",    i, {48'd0, a_bp}, {48'd0, tbl[i].e_bp});
      chk("b_out_data", i, b_d, tbl[i].e_db);
      chk("b_out_valid", i, {63'd0, b_ov}, {63'd0, tbl[i].e_ov});
      chk("c_bp_cnt",  i, {60'd0, c_bp}, {48'd0, tbl[i].e_bp});
    end

    // The flushed beat 0xD must never surface, even once the stage drains.
    chk("no_0xD", 100, {63'd0, (a_d == 64'hD)}, 64'd0);

    // Saturation: one beat held with downstream blocked for 20 cycles.
    drive(1, 1, 64'h41, 0, 0, 0);
    chk("sat_load", 200, c_d, 64'h41);
    for (int k = 1; k <= 20; k++) begin
      drive(1, 0, 64'h0, 0, 0, 0);
      chk("sat_c_bp", 200 + k, {60'd0, c_bp}, (k > 15) ? 64'd15 : 64'(k));
      chk("sat_a_bp", 200 + k, {48'd0, a_bp}, 64'(k));
    end
    drive(1, 0, 64'h0, 1, 0, 0);
    chk("sat_hold_c", 230, {60'd0, c_bp}, 64'd15);
    chk("sat_drain_ov", 230, {63'd0, c_ov}, 64'd0);
    chk("c_in_ready", 230, {63'd0, c_ir}, 64'd1);
    chk("b_in_ready", 230, {63'd0, b_ir}, 64'd1);
    chk("b_bp_cnt", 230, {48'd0, b_bp}, 64'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register, the next generation of the fixed 32-bit IF/ID latch. It carries an arbitrary-width payload with a valid bit, a ready/valid handshake on both sides and a two-entry skid buffer, so a stall no longer loses an upstream beat. Stall and flush are kept as explicit control inputs, and a saturating back-pressure counter is added. It instantiates between any two pipeline stages: IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- DATA_W, 64: payload width in bits (e.g. PC concatenated with instruction).
- CNT_W, 16: width of the back-pressure counter.
- ZERO_ON_FLUSH, 1: 1 means flush also zeroes the data registers; 0 means flush clears valid bits only.
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_n_i  input  1  reset, synchronous, active-low.
- in_valid_i  input  1  upstream beat present.
- in_data_i  input  DATA_W  upstream payload.
- in_ready_o  output  1  stage can accept a beat; registered.
- out_valid_o  output  1  downstream beat present.
- out_data_o  output  DATA_W  downstream payload; always the main register.
- out_ready_i  input  1  downstream can accept.
- stall_i  input  1  hazard hold; forces the effective downstream ready low.
- flush_i  input  1  discard all held and incoming beats.
- bp_cnt_o  output  CNT_W  saturating count of back-pressured cycles.

## Operation
- Definitions:
  - accept = in_valid_i & in_ready_o.
  - drain = out_valid_o & out_ready_i & ~stall_i.
- States:
  - EMPTY: no beat held.
  - FULL: main register valid.
  - SKID: main and skid registers both valid.
- Outputs by state:
  - in_ready_o = (state != SKID).
  - out_valid_o = (state != EMPTY).
- Transitions when there is no flush:
  - EMPTY, accept: go to FULL, main <= in_data_i.
  - FULL, accept & drain: stay in FULL, main <= in_data_i.
  - FULL, accept & ~drain: go to SKID, skid <= in_data_i.
  - FULL, ~accept & drain: go to EMPTY.
  - SKID, drain: go to FULL, main <= skid. Accept is impossible in SKID.
  - In all other cases state and data hold.
- Flush:
  - Next state is EMPTY.
  - Any beat accepted in the same cycle is discarded.
  - With ZERO_ON_FLUSH=1, main and skid are zeroed; otherwise data holds.
- Flush has priority over stall. This is the inverse of the previous latch, where stall won. Reset has priority over flush.
- Stall freezes main and skid contents but does not block upstream: a FULL stage can still absorb one beat into skid.
- Back-pressure counter:
  - bp_cnt_o increments on every cycle with out_valid_o & ~drain & ~flush_i.
  - It saturates at 2^CNT_W−1 and never wraps.
  - It clears only on reset; flush does not clear it.
- No combinational path runs from out_ready_i or stall_i to in_ready_o.

## Timing
- Values on reset (rst_n_i low at an edge):
  - state = EMPTY.
  - in_ready_o = 1.
  - out_valid_o = 0.
  - out_data_o = 0.
  - skid = 0.
  - bp_cnt_o = 0.
- Reset mid-operation drops all held beats and has no partial effect.
- Latency: a beat accepted at edge N is visible on out_data_o / out_valid_o after edge N, i.e. 1 cycle.
- Throughput: 1 beat per cycle when drain is continuous.
- A skid beat reaches out_data_o one cycle after the drain that frees main.
- After a flush at edge N: in_ready_o = 1 and out_valid_o = 0 from edge N on, and a new accept is possible in cycle N+1.
- Flush and stall both asserted: flush result, with bp_cnt_o not incremented.
- Ordering is preserved: the beat in main always leaves before the beat in skid.

## Structure
- Shared package pipe_pkg: the state typedef (EMPTY, FULL, SKID, 2-bit encoding) and a function returning the all-ones saturation value for CNT_W.
- One sub-module, pipe_sat_counter (parameter CNT_W; ports clk_i, rst_n_i, inc_i, cnt_o), reusable by other performance counters.
- Skid/main datapath and FSM stay inline.

## Test plan
- Reset, then hold in_valid_i=1 with data 0x1, 0x2, 0x3 on consecutive cycles, out_ready_i=1: out_data_o shows 0x1, 0x2, 0x3 one cycle later each; in_ready_o stays 1; bp_cnt_o = 0.
- Stall: main holds 0xA, stall_i=1 for 3 cycles while upstream offers 0xB then 0xC:
  - 0xB goes to skid and in_ready_o drops.
  - 0xC is held upstream.
  - bp_cnt_o = 3.
  - After release, output order is 0xA, 0xB, 0xC.
- Flush in SKID with ZERO_ON_FLUSH=1 and in_valid_i=1, data 0xD:
  - Next cycle out_valid_o = 0, in_ready_o = 1, out_data_o = 0.
  - 0xD never appears.
- Flush and stall together with ZERO_ON_FLUSH=0: state goes EMPTY, out_data_o keeps its old value, bp_cnt_o is unchanged.
- CNT_W=4, back-pressure held for 20 cycles: bp_cnt_o reaches 15 and stays 15.
- rst_n_i low for one cycle while in SKID: all outputs return to their reset values on the next cycle.
